// File: rtl/rv_defs_pkg.sv
// Shared definitions for the uRV writeback slice.
//   LDST_*  : funct3 load-width codes
//   wb_state_t : writeback stage state encoding
package rv_defs;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic [1:0] {
        WB_IDLE      = 2'd0,
        WB_ACTIVE    = 2'd1,
        WB_LOAD_WAIT = 2'd2
    } wb_state_t;

endpackage

// File: rtl/rv_load_align.sv
// Load data alignment: selects the addressed byte/half of the raw memory
// word and sign- or zero-extends it according to funct3.
//   fun   in  3   funct3 of the load
//   addr  in  2   low two bits of the byte address
//   raw   in  32  word returned by data memory
//   value out 32  extended load result
module rv_load_align
    import rv_defs::*;
(
    input  logic [2:0]  fun,
    input  logic [1:0]  addr,
    input  logic [31:0] raw,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = raw[7:0];
        case (addr)
            2'd0: byte_sel = raw[7:0];
            2'd1: byte_sel = raw[15:8];
            2'd2: byte_sel = raw[23:16];
            2'd3: byte_sel = raw[31:24];
            default: byte_sel = raw[7:0];
        endcase

        // addr[0] is ignored for halfword loads
        half_sel = addr[1] ? raw[31:16] : raw[15:0];

        value = raw;
        case (fun)
            LDST_B:  value = {{24{byte_sel[7]}}, byte_sel};
            LDST_H:  value = {{16{half_sel[15]}}, half_sel};
            LDST_W:  value = raw;
            LDST_BU: value = {24'b0, byte_sel};
            LDST_HU: value = {16'b0, half_sel};
            default: value = raw;
        endcase
    end

endmodule

// File: rtl/rv_writeback.sv
// Writeback stage of the uRV pipeline. Registers the execute result, waits
// for load completion, aligns load data and drives the register-file write
// port plus the W-stage bypass. Stalls upstream while a load is outstanding.
//
// state        | meaning
// -------------+---------------------------------------------------
// WB_IDLE      | nothing registered, no write
// WB_ACTIVE    | one non-load result registered, write this cycle
// WB_LOAD_WAIT | load registered, waiting for dm_load_done_i
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   x_*                          instruction presented by execute stage
//   dm_data_l_i, dm_load_done_i  data memory load return
//   w_rd_o, w_rd_value_o, w_rd_store_o   register-file write port
//   w_bypass_rd_write_o, w_bypass_rd_value_o  W-stage bypass
//   w_stall_o                    stall request to upstream stages
//   w_load_pending_o             load outstanding
module rv_writeback
    import rv_defs::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        x_valid_i,
    input  logic [4:0]  x_rd_i,
    input  logic [31:0] x_rd_value_i,
    input  logic        x_rd_write_i,
    input  logic        x_load_i,
    input  logic [2:0]  x_fun_i,
    input  logic [1:0]  x_dm_addr_i,
    input  logic [31:0] dm_data_l_i,
    input  logic        dm_load_done_i,
    output logic [4:0]  w_rd_o,
    output logic [31:0] w_rd_value_o,
    output logic        w_rd_store_o,
    output logic        w_bypass_rd_write_o,
    output logic [31:0] w_bypass_rd_value_o,
    output logic        w_stall_o,
    output logic        w_load_pending_o
);

    wb_state_t   state_q;
    logic [4:0]  rd_q;
    logic [31:0] value_q;
    logic        rd_write_q;
    logic [2:0]  fun_q;
    logic [1:0]  addr_q;

    logic [31:0] load_value;
    logic        load_wait;
    logic        stall;
    logic        accept;
    logic        write_ok;
    logic        store;

    rv_load_align u_align (
        .fun   (fun_q),
        .addr  (addr_q),
        .raw   (dm_data_l_i),
        .value (load_value)
    );

    assign load_wait = (state_q == WB_LOAD_WAIT);
    assign stall     = load_wait && !dm_load_done_i;
    assign accept    = x_valid_i && !stall;

    // Reset masks the write so a load completing in the reset cycle is dropped.
    assign write_ok = rd_write_q && (rd_q != 5'd0) && !rst_i;
    assign store    = write_ok && ((state_q == WB_ACTIVE) ||
                                   (load_wait && dm_load_done_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= WB_IDLE;
            rd_q       <= 5'd0;
            value_q    <= 32'd0;
            rd_write_q <= 1'b0;
            fun_q      <= 3'd0;
            addr_q     <= 2'd0;
        end else if (accept) begin
            state_q    <= x_load_i ? WB_LOAD_WAIT : WB_ACTIVE;
            rd_q       <= x_rd_i;
            value_q    <= x_rd_value_i;
            rd_write_q <= x_rd_write_i;
            fun_q      <= x_fun_i;
            addr_q     <= x_dm_addr_i;
        end else if (!stall) begin
            state_q    <= WB_IDLE;
        end
    end

    assign w_rd_o              = rd_q;
    assign w_rd_value_o        = load_wait ? load_value : value_q;
    assign w_rd_store_o        = store;
    assign w_bypass_rd_write_o = store;
    assign w_bypass_rd_value_o = w_rd_value_o;
    assign w_stall_o           = stall;
    assign w_load_pending_o    = load_wait;

endmodule

// File: tb/tb_rv_writeback.sv
module tb_rv_writeback;

    typedef struct {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        wr;
        logic        ld;
        logic [2:0]  fun;
        logic [1:0]  a;
    } instr_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        x_valid_i;
    logic [4:0]  x_rd_i;
    logic [31:0] x_rd_value_i;
    logic        x_rd_write_i;
    logic        x_load_i;
    logic [2:0]  x_fun_i;
    logic [1:0]  x_dm_addr_i;
    logic [31:0] dm_data_l_i;
    logic        dm_load_done_i;
    logic [4:0]  w_rd_o;
    logic [31:0] w_rd_value_o;
    logic        w_rd_store_o;
    logic        w_bypass_rd_write_o;
    logic [31:0] w_bypass_rd_value_o;
    logic        w_stall_o;
    logic        w_load_pending_o;

    int checks   = 0;
    int failures = 0;

    // model: the one instruction currently held by the stage, if any
    bit     m_busy = 1'b0;
    instr_t m_cur;
    logic   e_stall;

    rv_writeback dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .x_valid_i           (x_valid_i),
        .x_rd_i              (x_rd_i),
        .x_rd_value_i        (x_rd_value_i),
        .x_rd_write_i        (x_rd_write_i),
        .x_load_i            (x_load_i),
        .x_fun_i             (x_fun_i),
        .x_dm_addr_i         (x_dm_addr_i),
        .dm_data_l_i         (dm_data_l_i),
        .dm_load_done_i      (dm_load_done_i),
        .w_rd_o              (w_rd_o),
        .w_rd_value_o        (w_rd_value_o),
        .w_rd_store_o        (w_rd_store_o),
        .w_bypass_rd_write_o (w_bypass_rd_write_o),
        .w_bypass_rd_value_o (w_bypass_rd_value_o),
        .w_stall_o           (w_stall_o),
        .w_load_pending_o    (w_load_pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] fun, input logic [1:0] a,
                                             input logic [31:0] raw);
        logic [31:0] b;
        logic [31:0] h;
        b = raw >> (8 * a);
        h = raw >> (16 * a[1]);
        case (fun)
            3'b000:  return 32'($signed(b[7:0]));
            3'b001:  return 32'($signed(h[15:0]));
            3'b100:  return {24'd0, b[7:0]};
            3'b101:  return {16'd0, h[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic instr_t mk(input logic v, input logic [4:0] rd, input logic [31:0] val,
                                  input logic wr, input logic ld, input logic [2:0] fun,
                                  input logic [1:0] a);
        instr_t i;
        i.valid = v; i.rd = rd; i.val = val; i.wr = wr; i.ld = ld; i.fun = fun; i.a = a;
        return i;
    endfunction

    // Apply this cycle's inputs (called just after a falling edge) and
    // compare outputs against the model.
    task automatic drive(input logic rst, input instr_t ins, input logic done,
                         input logic [31:0] raw);
        logic        e_store;
        logic [31:0] e_val;
        rst_i          = rst;
        x_valid_i      = ins.valid;
        x_rd_i         = ins.rd;
        x_rd_value_i   = ins.val;
        x_rd_write_i   = ins.wr;
        x_load_i       = ins.ld;
        x_fun_i        = ins.fun;
        x_dm_addr_i    = ins.a;
        dm_load_done_i = done;
        dm_data_l_i    = raw;
        #1;
        e_stall = m_busy && m_cur.ld && !done;
        e_store = m_busy && m_cur.wr && (m_cur.rd != 0) && !rst && (!m_cur.ld || done);
        e_val   = m_cur.ld ? ref_load(m_cur.fun, m_cur.a, raw) : m_cur.val;
        chk("store",        {31'd0, w_rd_store_o},        {31'd0, e_store});
        chk("bypass_write", {31'd0, w_bypass_rd_write_o}, {31'd0, e_store});
        chk("stall",        {31'd0, w_stall_o},           {31'd0, e_stall});
        chk("load_pending", {31'd0, w_load_pending_o},    {31'd0, m_busy && m_cur.ld});
        if (e_store) begin
            chk("rd",           {27'd0, w_rd_o},     {27'd0, m_cur.rd});
            chk("value",        w_rd_value_o,        e_val);
            chk("bypass_value", w_bypass_rd_value_o, e_val);
        end
    endtask

    // Advance the model over the coming rising edge and wait for next falling edge.
    task automatic tick();
        if (rst_i) begin
            m_busy = 1'b0;
        end else if (x_valid_i && !e_stall) begin
            m_busy = 1'b1;
            m_cur  = mk(1'b1, x_rd_i, x_rd_value_i, x_rd_write_i, x_load_i, x_fun_i, x_dm_addr_i);
        end else if (!e_stall) begin
            m_busy = 1'b0;
        end
        @(negedge clk_i);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd"},  {27'd0, w_rd_o}, 32'd0);
        chk({tag, "_val"}, w_rd_value_o, 32'd0);
        chk({tag, "_st"},  {31'd0, w_rd_store_o}, 32'd0);
        chk({tag, "_bw"},  {31'd0, w_bypass_rd_write_o}, 32'd0);
        chk({tag, "_bv"},  w_bypass_rd_value_o, 32'd0);
        chk({tag, "_sl"},  {31'd0, w_stall_o}, 32'd0);
        chk({tag, "_lp"},  {31'd0, w_load_pending_o}, 32'd0);
    endtask

    instr_t nop;

    initial begin
        nop   = mk(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 3'd0, 2'd0);
        m_cur = nop;
        @(negedge clk_i);
        drive(1'b1, nop, 1'b0, 32'd0); tick();
        drive(1'b1, nop, 1'b0, 32'd0); tick();
        drive(1'b0, nop, 1'b0, 32'd0);
        chk_all_zero("reset");
        tick();

        // ALU result
        drive(1'b0, mk(1, 5'd5, 32'h12345678, 1, 0, 3'd0, 2'd0), 1'b0, 32'd0); tick();
        drive(1'b0, nop, 1'b0, 32'd0);
        chk("alu_store", {31'd0, w_rd_store_o}, 32'd1);
        chk("alu_value", w_rd_value_o, 32'h12345678);
        chk("alu_rd",    {27'd0, w_rd_o}, 32'd5);
        tick();
        drive(1'b0, nop, 1'b0, 32'd0);
        chk("alu_one_pulse", {31'd0, w_rd_store_o}, 32'd0);
        tick();

        // rd = 0
        drive(1'b0, mk(1, 5'd0, 32'hFFFFFFFF, 1, 0, 3'd0, 2'd0), 1'b0, 32'd0); tick();
        drive(1'b0, nop, 1'b0, 32'd0);
        chk("rd0_store",  {31'd0, w_rd_store_o}, 32'd0);
        chk("rd0_bypass", {31'd0, w_bypass_rd_write_o}, 32'd0);
        tick();

        // LB addr 3, done after 3 cycles
        drive(1'b0, mk(1, 5'd9, 32'd0, 1, 1, 3'b000, 2'd3), 1'b0, 32'd0); tick();
        drive(1'b0, nop, 1'b0, 32'h11111111);
        chk("lb_stall1", {31'd0, w_stall_o}, 32'd1);
        tick();
        drive(1'b0, nop, 1'b0, 32'h22222222);
        chk("lb_stall2", {31'd0, w_stall_o}, 32'd1);
        tick();
        drive(1'b0, nop, 1'b1, 32'h80AABBCC);
        chk("lb_stall3", {31'd0, w_stall_o}, 32'd0);
        chk("lb_value",  w_rd_value_o, 32'hFFFFFF80);
        chk("lb_store",  {31'd0, w_rd_store_o}, 32'd1);
        tick();

        // LHU / LH / LW at addr 2, each completing one cycle after accept
        drive(1'b0, mk(1, 5'd10, 32'd0, 1, 1, 3'b101, 2'd2), 1'b0, 32'd0); tick();
        drive(1'b0, mk(1, 5'd11, 32'd0, 1, 1, 3'b001, 2'd2), 1'b1, 32'hBEEF1234);
        chk("lhu_value", w_rd_value_o, 32'h0000BEEF);
        tick();
        drive(1'b0, mk(1, 5'd12, 32'd0, 1, 1, 3'b010, 2'd2), 1'b1, 32'hBEEF1234);
        chk("lh_value", w_rd_value_o, 32'hFFFFBEEF);
        tick();
        drive(1'b0, nop, 1'b1, 32'hBEEF1234);
        chk("lw_value", w_rd_value_o, 32'hBEEF1234);
        tick();

        // back-to-back ALU, ALU, load
        drive(1'b0, mk(1, 5'd1, 32'h1, 1, 0, 3'd0, 2'd0), 1'b0, 32'd0); tick();
        drive(1'b0, mk(1, 5'd2, 32'h2, 1, 0, 3'd0, 2'd0), 1'b0, 32'd0);
        chk("b2b_v1", w_rd_value_o, 32'h1);
        tick();
        drive(1'b0, mk(1, 5'd3, 32'd0, 1, 1, 3'b010, 2'd0), 1'b0, 32'd0);
        chk("b2b_v2", w_rd_value_o, 32'h2);
        tick();
        drive(1'b0, nop, 1'b1, 32'hCAFEF00D);
        chk("b2b_v3", w_rd_value_o, 32'hCAFEF00D);
        tick();

        // reset during LOAD_WAIT with done in the same cycle
        drive(1'b0, mk(1, 5'd7, 32'd0, 1, 1, 3'b010, 2'd0), 1'b0, 32'd0); tick();
        drive(1'b1, nop, 1'b1, 32'h5A5A5A5A);
        chk("rst_ld_store", {31'd0, w_rd_store_o}, 32'd0);
        tick();
        drive(1'b0, nop, 1'b0, 32'd0);
        chk_all_zero("rst_ld");
        tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            instr_t r;
            logic   rr;
            r  = mk(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
                    1'($urandom), 1'($urandom), 3'($urandom), 2'($urandom));
            rr = ($urandom_range(0, 63) == 0);
            drive(rr, r, 1'($urandom_range(0, 2) == 0), $urandom());
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
